wb_arbiter: RTL and testbench

Write-back controller for the integer register file's single write port. It arbitrates round-robin between the ALU and LSU result streams using valid/ready handshakes. The granted result is registered and drives the register file write port one cycle later. It also keeps a busy-bit scoreboard of destination registers with outstanding writes, which the issue stage uses to stall on RAW hazards.

---
 rtl/wb_pkg.sv | 24 ++
 rtl/wb_arbiter_if.sv | 56 +++++
 rtl/wb_scoreboard.sv | 56 +++++
 rtl/wb_arbiter.sv | 84 ++++++++
 tb/tb_wb_arbiter.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Purpose  : Shared constants and types for the write-back controller.
// Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = $clog2(NREG);

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_LSU = 1'b1
    } wb_gnt_e;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_if
// Purpose  : Result streams, register file write port and scoreboard queries.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_arbiter_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              alu_valid_i;
    logic [REG_AW-1:0] alu_rd_i;
    logic [XLEN-1:0]   alu_data_i;
    logic              alu_ready_o;

    logic              lsu_valid_i;
    logic [REG_AW-1:0] lsu_rd_i;
    logic [XLEN-1:0]   lsu_data_i;
    logic              lsu_ready_o;

    logic              rf_we_o;
    logic [REG_AW-1:0] rf_rd_o;
    logic [XLEN-1:0]   rf_wdata_o;

    logic              iss_valid_i;
    logic [REG_AW-1:0] iss_rd_i;
    logic [REG_AW-1:0] rs1_i;
    logic [REG_AW-1:0] rs2_i;
    logic              rs1_busy_o;
    logic              rs2_busy_o;
    logic              flush_i;

    // Write-back controller side
    modport slave (
        input  alu_valid_i, alu_rd_i, alu_data_i,
        output alu_ready_o,
        input  lsu_valid_i, lsu_rd_i, lsu_data_i,
        output lsu_ready_o,
        output rf_we_o, rf_rd_o, rf_wdata_o,
        input  iss_valid_i, iss_rd_i, rs1_i, rs2_i, flush_i,
        output rs1_busy_o, rs2_busy_o
    );

    // Pipeline side
    modport master (
        output alu_valid_i, alu_rd_i, alu_data_i,
        input  alu_ready_o,
        output lsu_valid_i, lsu_rd_i, lsu_data_i,
        input  lsu_ready_o,
        input  rf_we_o, rf_rd_o, rf_wdata_o,
        output iss_valid_i, iss_rd_i, rs1_i, rs2_i, flush_i,
        input  rs1_busy_o, rs2_busy_o
    );

endinterface : wb_arbiter_if
`default_nettype wire

// File: rtl/wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : wb_scoreboard
// Purpose  : Busy bits for destination registers with outstanding writes.
// Revision : 1.0 - initial release
// ============================================================================
module wb_scoreboard #(
    parameter int NREG   = 32,
    parameter int REG_AW = $clog2(NREG)
) (
    input  wire logic              clk_i,
    input  wire logic              rst_ni,
    input  wire logic              i_set,
    input  wire logic [REG_AW-1:0] i_set_rd,
    input  wire logic              i_clr,
    input  wire logic [REG_AW-1:0] i_clr_rd,
    input  wire logic              i_flush,
    input  wire logic [REG_AW-1:0] i_rs1,
    input  wire logic [REG_AW-1:0] i_rs2,
    output logic                   o_rs1_busy,
    output logic                   o_rs2_busy
);
    import wb_pkg::*;

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;

    // Set is applied after clear so a younger writer to the same rd keeps it busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_flush) begin
            w_busy_nxt = '0;
        end else begin
            if (i_clr) begin
                w_busy_nxt[i_clr_rd] = 1'b0;
            end
            if (i_set && (i_set_rd != '0)) begin
                w_busy_nxt[i_set_rd] = 1'b1;
            end
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign o_rs1_busy = rst_ni & r_busy[i_rs1];
    assign o_rs2_busy = rst_ni & r_busy[i_rs2];

endmodule : wb_scoreboard
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Round-robin ALU/LSU write-back arbiter with registered RF port.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  wire logic  clk_i,
    input  wire logic  rst_ni,
    wb_arbiter_if.slave bus
);
    import wb_pkg::*;

    localparam int REG_AW = $clog2(NREG);

    wb_gnt_e r_last_grant;
    wb_req_t r_out;
    logic    r_we;

    logic    w_alu_ready;
    logic    w_lsu_ready;
    logic    w_alu_hs;
    logic    w_lsu_hs;
    wb_req_t w_req;

    // Ready is a function of the other requester only, so at most one
    // handshake can complete per cycle.
    always_comb begin
        w_alu_ready = rst_ni && (!bus.lsu_valid_i || (r_last_grant == GNT_LSU));
        w_lsu_ready = rst_ni && (!bus.alu_valid_i || (r_last_grant == GNT_ALU));
        w_alu_hs    = bus.alu_valid_i && w_alu_ready;
        w_lsu_hs    = bus.lsu_valid_i && w_lsu_ready;
        w_req.rd    = bus.alu_rd_i;
        w_req.data  = bus.alu_data_i;
        if (w_lsu_hs) begin
            w_req.rd   = bus.lsu_rd_i;
            w_req.data = bus.lsu_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_last_grant <= GNT_LSU;
            r_we         <= 1'b0;
            r_out        <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_alu_hs || w_lsu_hs) begin
                r_out        <= w_req;
                r_we         <= (w_req.rd != '0);
                r_last_grant <= w_alu_hs ? GNT_ALU : GNT_LSU;
            end
        end
    end

    assign bus.alu_ready_o = w_alu_ready;
    assign bus.lsu_ready_o = w_lsu_ready;
    assign bus.rf_we_o     = r_we;
    assign bus.rf_rd_o     = r_out.rd;
    assign bus.rf_wdata_o  = r_out.data;

    // Busy clears on the same edge the register file commits.
    wb_scoreboard #(
        .NREG   (NREG),
        .REG_AW (REG_AW)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_set      (bus.iss_valid_i),
        .i_set_rd   (bus.iss_rd_i),
        .i_clr      (r_we),
        .i_clr_rd   (r_out.rd),
        .i_flush    (bus.flush_i),
        .i_rs1      (bus.rs1_i),
        .i_rs2      (bus.rs2_i),
        .o_rs1_busy (bus.rs1_busy_o),
        .o_rs2_busy (bus.rs2_busy_o)
    );

endmodule : wb_arbiter
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Purpose  : Cycle-table bench for wb_arbiter with a write scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;
    import wb_pkg::*;

    typedef struct {
        logic        rst_n;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        fl;
        logic        e_ar;
        logic        e_lr;
        logic        e_we;
        logic        e_b1;
        logic        e_b2;
        int          push;   // 0 none, 1 ALU request, 2 LSU request
    } vec_t;

    localparam logic [31:0] c_a = 32'hAAAA_0001;
    localparam logic [31:0] c_l = 32'h5555_0002;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    vec_t    vecs[$];
    wb_req_t exp_q[$];

    wb_arbiter_if #(.XLEN(32), .REG_AW(5)) bus ();

    wb_arbiter #(.XLEN(32), .NREG(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(
        logic rst_n_f, logic av, logic [4:0] ard, logic [31:0] adat,
        logic lv, logic [4:0] lrd, logic [31:0] ldat,
        logic iv, logic [4:0] ird, logic [4:0] rs1, logic [4:0] rs2, logic fl,
        logic e_ar, logic e_lr, logic e_we, logic e_b1, logic e_b2, int push);
        vec_t r;
        r.rst_n = rst_n_f; r.av = av; r.ard = ard; r.adat = adat;
        r.lv = lv; r.lrd = lrd; r.ldat = ldat;
        r.iv = iv; r.ird = ird; r.rs1 = rs1; r.rs2 = rs2; r.fl = fl;
        r.e_ar = e_ar; r.e_lr = e_lr; r.e_we = e_we;
        r.e_b1 = e_b1; r.e_b2 = e_b2; r.push = push;
        return r;
    endfunction

    task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(vec_t x);
        rst_n           = x.rst_n;
        bus.alu_valid_i = x.av;
        bus.alu_rd_i    = x.ard;
        bus.alu_data_i  = x.adat;
        bus.lsu_valid_i = x.lv;
        bus.lsu_rd_i    = x.lrd;
        bus.lsu_data_i  = x.ldat;
        bus.iss_valid_i = x.iv;
        bus.iss_rd_i    = x.ird;
        bus.rs1_i       = x.rs1;
        bus.rs2_i       = x.rs2;
        bus.flush_i     = x.fl;
    endtask

    // Pops the expected write whenever the port asserts its enable.
    task automatic pop_write(int idx);
        wb_req_t e;
        if (bus.rf_we_o === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write (step %0d): got rd %0d, expected no write",
                         idx, bus.rf_rd_o);
            end else begin
                e = exp_q.pop_front();
                n_cmp--;
                check("rf_rd", idx, 32'(bus.rf_rd_o), 32'(e.rd));
                check("rf_wdata", idx, bus.rf_wdata_o, e.data);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // Reset with both requesters already valid.
        vecs.push_back(v(0,1,5,c_a,1,6,c_l,0,0,5,6,0, 0,0,0,0,0,0));
        vecs.push_back(v(0,1,5,c_a,1,6,c_l,0,0,5,6,0, 0,0,0,0,0,0));
        // Conflict: strict alternation, ALU first, four grants each.
        for (int k = 0; k < 8; k++) begin
            vecs.push_back(v(1,1,5,c_a,1,6,c_l,0,0,5,6,0,
                             (k % 2 == 0), (k % 2 == 1), (k != 0), 0, 0,
                             (k % 2 == 0) ? 1 : 2));
        end
        vecs.push_back(v(1,0,0,0,0,0,0,0,0,0,0,0, 1,1,1,0,0,0));
        // x0 request handshakes but never writes.
        vecs.push_back(v(1,1,0,32'hDEAD_BEEF,0,0,0,0,0,0,0,0, 1,0,0,0,0,1));
        vecs.push_back(v(1,0,0,0,0,0,0,0,0,0,0,0, 1,1,0,0,0,0));
        // Scoreboard set then commit-edge clear on x7.
        vecs.push_back(v(1,0,0,0,0,0,0,1,7,7,0,0, 1,1,0,0,0,0));
        vecs.push_back(v(1,1,7,32'h0000_0077,0,0,0,0,0,7,0,0, 1,1,0,1,0,1));
        vecs.push_back(v(1,0,0,0,0,0,0,0,0,7,0,0, 1,1,1,1,0,0));
        vecs.push_back(v(1,0,0,0,0,0,0,0,0,7,0,0, 1,1,0,0,0,0));
        // Re-issue of x7 on the commit edge keeps it busy.
        vecs.push_back(v(1,0,0,0,0,0,0,1,7,7,0,0, 1,1,0,0,0,0));
        vecs.push_back(v(1,1,7,32'h0000_0078,0,0,0,0,0,7,0,0, 1,1,0,1,0,1));
        vecs.push_back(v(1,0,0,0,0,0,0,1,7,7,0,0, 1,1,1,1,0,0));
        vecs.push_back(v(1,0,0,0,0,0,0,0,0,7,0,0, 1,1,0,1,0,0));
        // Flush with x3 write in the output stage.
        vecs.push_back(v(1,0,0,0,0,0,0,1,3,3,4,0, 1,1,0,0,0,0));
        vecs.push_back(v(1,0,0,0,0,0,0,1,4,3,4,0, 1,1,0,1,0,0));
        vecs.push_back(v(1,0,0,0,1,3,32'h3333_0003,0,0,3,4,0, 0,1,0,1,1,2));
        vecs.push_back(v(1,0,0,0,0,0,0,0,0,3,4,1, 1,1,1,1,1,0));
        vecs.push_back(v(1,0,0,0,0,0,0,0,0,3,7,0, 1,1,0,0,0,0));
        // Reset right after an x9 handshake and issue.
        vecs.push_back(v(1,1,9,32'h9999_0009,0,0,0,1,9,9,0,0, 1,0,0,0,0,1));
        vecs.push_back(v(0,0,0,0,0,0,0,0,0,9,0,0, 0,0,1,0,0,0));
        vecs.push_back(v(1,0,0,0,0,0,0,0,0,9,0,0, 1,1,0,0,0,0));
        // Grant state is back to LSU after reset: ALU wins.
        vecs.push_back(v(1,1,10,32'h0000_A0A0,1,11,32'h0000_B0B0,0,0,0,0,0, 1,0,0,0,0,1));
        vecs.push_back(v(1,0,0,0,0,0,0,0,0,0,0,0, 1,1,1,0,0,0));

        drive(vecs[0]);
        @(posedge clk);
        #1;
        check("reset_rf_we", -1, 32'(bus.rf_we_o), 32'd0);
        check("reset_rf_rd", -1, 32'(bus.rf_rd_o), 32'd0);
        check("reset_rf_wdata", -1, bus.rf_wdata_o, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(negedge clk);
            check("alu_ready", i, 32'(bus.alu_ready_o), 32'(vecs[i].e_ar));
            check("lsu_ready", i, 32'(bus.lsu_ready_o), 32'(vecs[i].e_lr));
            check("rf_we", i, 32'(bus.rf_we_o), 32'(vecs[i].e_we));
            check("rs1_busy", i, 32'(bus.rs1_busy_o), 32'(vecs[i].e_b1));
            check("rs2_busy", i, 32'(bus.rs2_busy_o), 32'(vecs[i].e_b2));
            pop_write(i);
            if (vecs[i].push == 1 && vecs[i].ard != 5'd0)
                exp_q.push_back('{rd: vecs[i].ard, data: vecs[i].adat});
            else if (vecs[i].push == 2 && vecs[i].lrd != 5'd0)
                exp_q.push_back('{rd: vecs[i].lrd, data: vecs[i].ldat});
            @(posedge clk);
            #1;
        end

        // Idle cycle: port disabled but address/data hold the last write.
        @(negedge clk);
        check("idle_rf_we", 99, 32'(bus.rf_we_o), 32'd0);
        check("hold_rf_rd", 99, 32'(bus.rf_rd_o), 32'd10);
        check("hold_rf_wdata", 99, bus.rf_wdata_o, 32'h0000_A0A0);
        pop_write(99);
        check("pending_writes", 99, 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_wb_arbiter
`default_nettype wire
